dt_feature_framer: RTL and testbench

- Producer-side front end for the fixed-point decision-tree fault classifiers; it builds the six-lane Va,Vb,Vc,Ia,Ib,Ic vector those classifiers consume.
- Accepts a tagged stream of signed ADC samples, one channel per beat.
- Converts each sample to N-bit offset-binary features and assembles complete frames.
- Presents each frame on a valid/ready output with stable, registered lanes.

---
 rtl/dt_feature_framer.sv | 120 ++++++++++++
 tb/tb_dt_feature_framer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/dt_feature_framer.sv
// Six-lane feature framer: turns a tagged signed ADC sample stream into offset-binary
// Va..Ic frames on a registered valid/ready output. Optional counters under DT_FRAME_CNT_EN.
module dt_feature_framer #(
  parameter int N = 8,
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [2:0]   s_chan,
  input  logic [W-1:0] s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [N-1:0] Va,
  output logic [N-1:0] Vb,
  output logic [N-1:0] Vc,
  output logic [N-1:0] Ia,
  output logic [N-1:0] Ib,
  output logic [N-1:0] Ic,
`ifdef DT_FRAME_CNT_EN
  output logic [15:0]  frame_cnt,
  output logic [7:0]   drop_cnt,
`endif
  output logic         seq_err
);

  logic [N-1:0] asm_q  [6];
  logic [N-1:0] lane_q [6];
  logic [2:0]   idx;
  logic         pending;

  logic [W-1:0] u;
  logic [N-1:0] feature;
  logic         accept;
  logic         in_order;
  logic         out_hs;
  logic         out_free;

  // Offset binary is the two's-complement sample with its sign bit flipped; keep the top N bits.
  assign u        = {~s_data[W-1], s_data[W-2:0]};
  assign feature  = u[W-1:W-N];

  assign s_ready  = !pending;
  assign accept   = s_valid && s_ready;
  assign in_order = (s_chan == idx);
  assign out_hs   = m_valid && m_ready;
  assign out_free = !m_valid || m_ready;

  assign Va = lane_q[0];
  assign Vb = lane_q[1];
  assign Vc = lane_q[2];
  assign Ia = lane_q[3];
  assign Ib = lane_q[4];
  assign Ic = lane_q[5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) begin
        asm_q[i]  <= '0;
        lane_q[i] <= '0;
      end
      idx     <= 3'd0;
      pending <= 1'b0;
      m_valid <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      seq_err <= 1'b0;
      if (pending) begin
        // A held frame replaces the one being consumed, so m_valid stays high.
        if (out_hs) begin
          for (int i = 0; i < 6; i++) lane_q[i] <= asm_q[i];
          pending <= 1'b0;
          idx     <= 3'd0;
        end
      end else begin
        if (out_hs) m_valid <= 1'b0;
        if (accept) begin
          if (in_order) begin
            asm_q[idx] <= feature;
            if (idx == 3'd5) begin
              if (out_free) begin
                for (int i = 0; i < 5; i++) lane_q[i] <= asm_q[i];
                lane_q[5] <= feature;
                m_valid   <= 1'b1;
                idx       <= 3'd0;
              end else begin
                pending <= 1'b1;
              end
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            // A stray Va starts a fresh frame instead of being thrown away.
            seq_err <= 1'b1;
            if (s_chan == 3'd0) begin
              asm_q[0] <= feature;
              idx      <= 3'd1;
            end else begin
              idx <= 3'd0;
            end
          end
        end
      end
    end
  end

`ifdef DT_FRAME_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 16'd0;
      drop_cnt  <= 8'd0;
    end else begin
      if (out_hs) frame_cnt <= frame_cnt + 16'd1;
      if (accept && !in_order && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dt_feature_framer.sv
// Directed bench for dt_feature_framer: table of frames with hand-computed lanes plus
// sequences for backpressure, order errors, resync, reset and the DT_FRAME_CNT_EN counters.
module tb_dt_feature_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [2:0]  s_chan;
  logic [11:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  Va, Vb, Vc, Ia, Ib, Ic;
  logic        seq_err;
`ifdef DT_FRAME_CNT_EN
  logic [15:0] frame_cnt;
  logic [7:0]  drop_cnt;
`endif
  logic [47:0] lanes;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [5:0][11:0] data;
    logic [47:0]      exp;
  } frame_vec_t;

  frame_vec_t vec [4];

  assign lanes = {Va, Vb, Vc, Ia, Ib, Ic};

  always #5 clk = ~clk;

  dt_feature_framer #(.N(8), .W(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_chan(s_chan), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready),
    .Va(Va), .Vb(Vb), .Vc(Vc), .Ia(Ia), .Ib(Ib), .Ic(Ic),
`ifdef DT_FRAME_CNT_EN
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
`endif
    .seq_err(seq_err)
  );

  function automatic frame_vec_t mkVec(input logic [11:0] d0, d1, d2, d3, d4, d5,
                                       input logic [47:0] e);
    frame_vec_t v;
    v.data[0] = d0; v.data[1] = d1; v.data[2] = d2;
    v.data[3] = d3; v.data[4] = d4; v.data[5] = d5;
    v.exp = e;
    return v;
  endfunction

  // Drive one beat and return 1 ns after the edge that consumes it.
  task automatic applyStimulus(input logic valid, input logic [2:0] chan, input logic [11:0] data);
    s_valid = valid;
    s_chan  = chan;
    s_data  = data;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic sendFrame(input frame_vec_t v, output logic errSeen);
    errSeen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 3'(i), v.data[i]);
      errSeen = errSeen | seq_err;
    end
  endtask

  task automatic idle();
    applyStimulus(1'b0, 3'd0, 12'h000);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic errSeen;

    vec[0] = mkVec(12'h000, 12'h7FF, 12'h800, 12'h123, 12'hFFF, 12'h400, 48'h80_FF_00_92_7F_C0);
    vec[1] = mkVec(12'h010, 12'h020, 12'h7F0, 12'h80F, 12'h555, 12'hAAA, 48'h81_82_FF_00_D5_2A);
    vec[2] = mkVec(12'h001, 12'h00F, 12'hF00, 12'h0A5, 12'h3C3, 12'hC3C, 48'h80_80_70_8A_BC_43);
    vec[3] = mkVec(12'h100, 12'h200, 12'h300, 12'h900, 12'hA00, 12'hB00, 48'h90_A0_B0_10_20_30);

    rst_n = 1'b0; s_valid = 1'b0; s_chan = 3'd0; s_data = 12'h000; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_m_valid", 48'(m_valid), 48'd0);
    checkOutput("reset_lanes",   lanes,        48'd0);
    checkOutput("reset_s_ready", 48'(s_ready), 48'd1);
    checkOutput("reset_seq_err", 48'(seq_err), 48'd0);
    rst_n = 1'b1;
    idle();

    $display("[TB] back-to-back frames, m_ready=1");
    for (int f = 0; f < 4; f++) begin
      errSeen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        applyStimulus(1'b1, 3'(i), vec[f].data[i]);
        errSeen = errSeen | seq_err;
        if (i == 0 && f > 0) checkOutput($sformatf("loop%0d_prev_consumed", f), 48'(m_valid), 48'd0);
      end
      checkOutput($sformatf("loop%0d_m_valid", f), 48'(m_valid), 48'd1);
      checkOutput($sformatf("loop%0d_lanes", f),   lanes,        vec[f].exp);
      checkOutput($sformatf("loop%0d_seq_err", f), 48'(errSeen), 48'd0);
    end
    idle();
    checkOutput("loop_end_m_valid", 48'(m_valid), 48'd0);
    checkOutput("loop_end_lanes_hold", lanes, vec[3].exp);

    $display("[TB] backpressure");
    m_ready = 1'b0;
    sendFrame(vec[0], errSeen);
    checkOutput("bp_first_m_valid", 48'(m_valid), 48'd1);
    checkOutput("bp_first_lanes",   lanes,        vec[0].exp);
    sendFrame(vec[1], errSeen);
    checkOutput("bp_s_ready_low",    48'(s_ready), 48'd0);
    checkOutput("bp_held_m_valid",   48'(m_valid), 48'd1);
    checkOutput("bp_held_lanes",     lanes,        vec[0].exp);
    idle();
    idle();
    checkOutput("bp_still_pending",  48'(s_ready), 48'd0);
    checkOutput("bp_still_lanes",    lanes,        vec[0].exp);
    m_ready = 1'b1;
    idle();
    m_ready = 1'b0;
    checkOutput("bp_second_m_valid", 48'(m_valid), 48'd1);
    checkOutput("bp_second_lanes",   lanes,        vec[1].exp);
    checkOutput("bp_s_ready_back",   48'(s_ready), 48'd1);
    m_ready = 1'b1;
    idle();
    checkOutput("bp_drained_m_valid", 48'(m_valid), 48'd0);
    checkOutput("bp_drained_lanes",   lanes,        vec[1].exp);

    $display("[TB] order error 0,1,3");
    applyStimulus(1'b1, 3'd0, 12'h111);
    applyStimulus(1'b1, 3'd1, 12'h222);
    applyStimulus(1'b1, 3'd3, 12'h333);
    checkOutput("oe_seq_err_pulse", 48'(seq_err), 48'd1);
    idle();
    checkOutput("oe_seq_err_clear", 48'(seq_err), 48'd0);
    checkOutput("oe_no_frame",      48'(m_valid), 48'd0);
    sendFrame(vec[2], errSeen);
    checkOutput("oe_recover_err",     48'(errSeen), 48'd0);
    checkOutput("oe_recover_m_valid", 48'(m_valid), 48'd1);
    checkOutput("oe_recover_lanes",   lanes,        vec[2].exp);
    idle();
    checkOutput("oe_single_frame",    48'(m_valid), 48'd0);

    $display("[TB] resync 0,1,2,0..5");
    applyStimulus(1'b1, 3'd0, 12'hFFF);
    applyStimulus(1'b1, 3'd1, 12'hFFF);
    applyStimulus(1'b1, 3'd2, 12'hFFF);
    applyStimulus(1'b1, 3'd0, vec[3].data[0]);
    checkOutput("rs_seq_err_pulse", 48'(seq_err), 48'd1);
    errSeen = 1'b0;
    for (int i = 1; i < 6; i++) begin
      applyStimulus(1'b1, 3'(i), vec[3].data[i]);
      errSeen = errSeen | seq_err;
    end
    checkOutput("rs_single_pulse", 48'(errSeen), 48'd0);
    checkOutput("rs_m_valid",      48'(m_valid), 48'd1);
    checkOutput("rs_lanes",        lanes,        vec[3].exp);
    idle();
    checkOutput("rs_single_frame", 48'(m_valid), 48'd0);

    $display("[TB] reset mid-frame with held frame");
    m_ready = 1'b0;
    sendFrame(vec[0], errSeen);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 3'(i), vec[2].data[i]);
    s_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_m_valid", 48'(m_valid), 48'd0);
    checkOutput("rst_async_lanes",   lanes,        48'd0);
    checkOutput("rst_async_s_ready", 48'(s_ready), 48'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_ready = 1'b1;
    idle();
    checkOutput("rst_post_m_valid", 48'(m_valid), 48'd0);
    sendFrame(vec[1], errSeen);
    checkOutput("rst_fresh_err",     48'(errSeen), 48'd0);
    checkOutput("rst_fresh_m_valid", 48'(m_valid), 48'd1);
    checkOutput("rst_fresh_lanes",   lanes,        vec[1].exp);
    idle();
    checkOutput("rst_single_frame",  48'(m_valid), 48'd0);

`ifdef DT_FRAME_CNT_EN
    $display("[TB] frame and drop counters");
    rst_n = 1'b0;
    #2;
    checkOutput("cnt_reset_frame", 48'(frame_cnt), 48'd0);
    checkOutput("cnt_reset_drop",  48'(drop_cnt),  48'd0);
    rst_n = 1'b1;
    idle();
    for (int f = 0; f < 3; f++) sendFrame(vec[f], errSeen);
    idle();
    idle();
    checkOutput("cnt_frames_3", 48'(frame_cnt), 48'd3);
    applyStimulus(1'b1, 3'd2, 12'h000);
    applyStimulus(1'b1, 3'd2, 12'h000);
    idle();
    checkOutput("cnt_drops_2", 48'(drop_cnt), 48'd2);
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 3'd7, 12'h000);
    idle();
    checkOutput("cnt_drops_sat",  48'(drop_cnt),  48'd255);
    checkOutput("cnt_frames_kept", 48'(frame_cnt), 48'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
